// File: rtl/register_file.sv
// register_file: 32x32 register file, R0 hardwired to zero, two read ports plus a never-bypassed debug port
module register_file #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        Clock,
  input  logic        NReset,
  input  logic        WriteEnable,
  input  logic [4:0]  WriteAddr,
  input  logic [31:0] WriteData,
  input  logic [4:0]  ReadAddrA,
  input  logic [4:0]  ReadAddrB,
  output logic [31:0] ReadDataA,
  output logic [31:0] ReadDataB,
  input  logic [4:0]  DebugAddr,
  output logic [31:0] DebugData
);
  logic [31:0] r [32];
  logic        wr;
  always_ff @(posedge Clock or negedge NReset)
    if (!NReset) for (int i = 0; i < 32; i++) r[i] <= '0;
    else if (wr) r[WriteAddr] <= WriteData;
  // reads are gated by NReset so forwarding cannot leak write data during reset
  always_comb begin
    wr        = NReset && WriteEnable && WriteAddr != 5'd0;
    ReadDataA = !NReset || ReadAddrA == 5'd0 ? '0 :
                BYPASS && wr && ReadAddrA == WriteAddr ? WriteData : r[ReadAddrA];
    ReadDataB = !NReset || ReadAddrB == 5'd0 ? '0 :
                BYPASS && wr && ReadAddrB == WriteAddr ? WriteData : r[ReadAddrB];
    DebugData = !NReset || DebugAddr == 5'd0 ? '0 : r[DebugAddr];
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of both BYPASS variants driven from shared stimulus
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b1;
  logic [4:0]  wa = '0, ra = '0, rb = '0, da = '0;
  logic [31:0] wd = 32'h5555_5555;
  logic [31:0] a1, b1, d1, a0, b0, d0;
  logic [31:0] m [32];
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  register_file #(.BYPASS(1'b1)) u1 (
    .Clock(clk), .NReset(rst_n), .WriteEnable(we), .WriteAddr(wa), .WriteData(wd),
    .ReadAddrA(ra), .ReadAddrB(rb), .ReadDataA(a1), .ReadDataB(b1),
    .DebugAddr(da), .DebugData(d1)
  );
  register_file #(.BYPASS(1'b0)) u0 (
    .Clock(clk), .NReset(rst_n), .WriteEnable(we), .WriteAddr(wa), .WriteData(wd),
    .ReadAddrA(ra), .ReadAddrB(rb), .ReadDataA(a0), .ReadDataB(b0),
    .DebugAddr(da), .DebugData(d0)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk);
    #1 we = 1'b0;
    if (a != 5'd0) m[a] = d;
  endtask
  // one address per cycle; during reset the write port chases the read address to probe forwarding
  task automatic sweep(input string tag, input bit in_rst);
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      ra = 5'(j); rb = 5'(31 - j); da = 5'(j);
      if (in_rst) begin we = 1'b1; wa = 5'(j); wd = 32'hFFFF_FFFF; end
      #1;
      check({tag, "_a1"}, a1, in_rst ? 32'h0 : m[j]);
      check({tag, "_b1"}, b1, in_rst ? 32'h0 : m[31 - j]);
      check({tag, "_d1"}, d1, in_rst ? 32'h0 : m[j]);
      check({tag, "_a0"}, a0, in_rst ? 32'h0 : m[j]);
      check({tag, "_b0"}, b0, in_rst ? 32'h0 : m[31 - j]);
      check({tag, "_d0"}, d0, in_rst ? 32'h0 : m[j]);
    end
    we = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m[i] = '0;
    sweep("rst", 1'b1);
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0;
    wr(5'd5, 32'hDEAD_BEEF);
    @(negedge clk); ra = 5'd5; #1;
    check("r5_a1", a1, 32'hDEAD_BEEF);
    check("r5_a0", a0, 32'hDEAD_BEEF);
    wr(5'd0, 32'hFFFF_FFFF);
    @(negedge clk); ra = 5'd0; rb = 5'd0; da = 5'd0; #1;
    check("r0_a1", a1, 32'h0); check("r0_b1", b1, 32'h0); check("r0_d1", d1, 32'h0);
    check("r0_a0", a0, 32'h0); check("r0_b0", b0, 32'h0); check("r0_d0", d0, 32'h0);
    wr(5'd7, 32'h1111_1111);
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 32'h2222_2222; ra = 5'd7; rb = 5'd7; da = 5'd7; #1;
    check("byp_a1", a1, 32'h2222_2222); check("byp_b1", b1, 32'h2222_2222);
    check("byp_a0", a0, 32'h1111_1111); check("byp_b0", b0, 32'h1111_1111);
    check("byp_d1", d1, 32'h1111_1111); check("byp_d0", d0, 32'h1111_1111);
    @(posedge clk);
    #1 we = 1'b0; m[7] = 32'h2222_2222; #1;
    check("post_a0", a0, 32'h2222_2222); check("post_b0", b0, 32'h2222_2222);
    check("post_d0", d0, 32'h2222_2222);
    @(negedge clk);
    we = 1'b1; wa = 5'd10; wd = 32'hAAAA_5555; ra = 5'd10; rb = 5'd7; da = 5'd10; #1;
    check("split_a1", a1, 32'hAAAA_5555); check("split_b1", b1, 32'h2222_2222);
    check("split_a0", a0, 32'h0); check("split_d1", d1, 32'h0);
    @(posedge clk);
    #1 we = 1'b0; m[10] = 32'hAAAA_5555;
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    sweep("fill", 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0; we = 1'b1; wa = 5'd9; wd = 32'h99; ra = 5'd9; rb = 5'd31; da = 5'd1; #1;
    check("async_a1", a1, 32'h0); check("async_b1", b1, 32'h0); check("async_d1", d1, 32'h0);
    check("async_a0", a0, 32'h0); check("async_b0", b0, 32'h0); check("async_d0", d0, 32'h0);
    for (int i = 0; i < 32; i++) m[i] = '0;
    sweep("mid_rst", 1'b1);
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0;
    sweep("after_rst", 1'b0);
    wr(5'd9, 32'h0000_0ABC);
    @(negedge clk); ra = 5'd9; da = 5'd9; #1;
    check("first_wr_a1", a1, 32'h0000_0ABC);
    check("first_wr_d0", d0, 32'h0000_0ABC);
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h1 << i);
    sweep("walk", 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to matching read ports; 0 returns the stored value.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port NReset, input, 1 bit: asynchronous, active-low reset; asserted 0 clears all state immediately, independent of Clock.
REQ-004 The block SHALL have port WriteEnable, input, 1 bit: the write request, sampled at the Clock rising edge.
REQ-005 The block SHALL have port WriteAddr, input, 5 bits: the destination register index.
REQ-006 The block SHALL have port WriteData, input, 32 bits: the data to store.
REQ-007 The block SHALL have ports ReadAddrA and ReadAddrB, input, 5 bits each: the source register indices.
REQ-008 The block SHALL have ports ReadDataA and ReadDataB, output, 32 bits each: the read results.
REQ-009 The block SHALL have port DebugAddr, input, 5 bits: the debug/inspection read index.
REQ-010 The block SHALL have port DebugData, output, 32 bits: the debug read result; it is never bypassed.

Function
REQ-011 The block SHALL hold 32 registers R0..R31, each 32 bits.
REQ-012 On a Clock rising edge with NReset=1 and WriteEnable=1 and WriteAddr!=0, R[WriteAddr] SHALL take WriteData, visible in storage from the next cycle.
REQ-013 A write with WriteAddr=0 SHALL be discarded; R0 SHALL always read 32'h00000000 on every port.
REQ-014 With WriteEnable=0, no register SHALL change.
REQ-015 ReadDataA SHALL equal R[ReadAddrA] combinationally (zero cycles of latency); the same SHALL hold for ReadDataB with ReadAddrB, and for DebugData with DebugAddr.
REQ-016 With BYPASS=1, WriteEnable=1, WriteAddr!=0 and ReadAddrX==WriteAddr in the same cycle, ReadDataX SHALL equal WriteData, applied independently per port A and B.
REQ-017 With BYPASS=0, the read ports SHALL return the pre-edge stored value in the write cycle.
REQ-018 When both read ports address the same register, both SHALL return identical data, including the bypass case.
REQ-019 Reads SHALL have no side effects; any number of reads per cycle is allowed.
REQ-020 Address values are the full range 0..31; there SHALL be no out-of-range case and no wrap logic.

Reset
REQ-021 When NReset=0, all R1..R31 SHALL clear to 32'h00000000 asynchronously, without waiting for a Clock edge.
REQ-022 While NReset=0, writes SHALL be ignored, and ReadDataA, ReadDataB and DebugData SHALL be 0, including with BYPASS=1.
REQ-023 If NReset falls in the same cycle as a write, the write SHALL be lost and the register SHALL be 0.
REQ-024 After NReset deasserts, the first Clock rising edge with NReset=1 SHALL perform a normal write.

Verification
REQ-025 Reset then read: NReset=0 -> all 32 registers read 0 on A, B and Debug.
REQ-026 Basic write/read: write R5=32'hDEADBEEF, next cycle ReadAddrA=5 -> ReadDataA=32'hDEADBEEF.
REQ-027 Zero register: write R0=32'hFFFFFFFF, then read R0 on A, B and Debug -> 0 on all three.
REQ-028 Bypass behaviour: R7=32'h11111111; same cycle write R7=32'h22222222 with ReadAddrA=ReadAddrB=7.
- BYPASS=1 -> both A and B = 32'h22222222.
- BYPASS=0 -> both A and B = 32'h11111111, then 32'h22222222 the next cycle.
- DebugAddr=7 in the write cycle -> DebugData=32'h11111111 for either BYPASS value.
REQ-029 Asynchronous reset mid-operation: fill R1..R31 with their own indices, pulse NReset=0 between Clock edges -> all reads 0 immediately; a WriteEnable held during reset leaves the target register at 0.
REQ-030 Walking pattern: write R[i]=1<<i for i=1..31, then sweep ReadAddrA/ReadAddrB/DebugAddr over all indices -> exact match and no aliasing between registers.
